qsm_accum: RTL and testbench

//  Sequential sign-magnitude Q-format accumulator: the producer/consumer end of the team's sign-magnitude add path.

---
 rtl/qsm_pkg.sv | 19 +
 rtl/qsm_add_core.sv | 54 +++++
 rtl/qsm_accum.sv | 105 ++++++++++
 tb/tb_qsm_accum.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/qsm_pkg.sv
// Shared constants and FSM encoding for the sign-magnitude Q-format accumulator.
// Word layout: bit SIGN_BIT is the sign, bits SIGN_BIT-1:0 are the magnitude.
package qsm_pkg;

    localparam int unsigned Q        = 23;
    localparam int unsigned N        = 32;
    localparam int unsigned LW       = 16;
    localparam int unsigned SIGN_BIT = N - 1;

    localparam logic [N-2:0] MAG_MAX  = '1;
    localparam logic [N-1:0] POS_ZERO = '0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StDone = 2'd2
    } qsm_state_e;

endpackage

// File: rtl/qsm_add_core.sv
// Combinational sign-magnitude adder with magnitude-carry overflow flag.
// Optional feature: QSM_ACCUM_SAT_EN clamps an overflowed magnitude to all-ones
// (sign kept); without it the carry is dropped and the magnitude wraps.
module qsm_add_core
    import qsm_pkg::*;
(
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o,
    output logic         ovf_o
);

    logic [N-2:0] mag_a;
    logic [N-2:0] mag_b;
    logic [N-2:0] mag_r;
    logic         sgn_a;
    logic         sgn_b;
    logic         sgn_r;
    logic [N-1:0] mag_sum;

    // Magnitude add/subtract selected by operand signs; -0 inputs count as +0.
    always_comb begin
        mag_a   = a_i[N-2:0];
        mag_b   = b_i[N-2:0];
        sgn_a   = a_i[SIGN_BIT] & (mag_a != '0);
        sgn_b   = b_i[SIGN_BIT] & (mag_b != '0);
        mag_sum = {1'b0, mag_a} + {1'b0, mag_b};
        mag_r   = '0;
        sgn_r   = 1'b0;
        ovf_o   = 1'b0;
        if (sgn_a == sgn_b) begin
            sgn_r = sgn_a;
            ovf_o = mag_sum[N-1];
            mag_r = mag_sum[N-2:0];
`ifdef QSM_ACCUM_SAT_EN
            if (mag_sum[N-1]) begin
                mag_r = MAG_MAX;
            end
`endif
        end else if (mag_a > mag_b) begin
            sgn_r = sgn_a;
            mag_r = mag_a - mag_b;
        end else if (mag_b > mag_a) begin
            sgn_r = sgn_b;
            mag_r = mag_b - mag_a;
        end
        // A zero magnitude is always reported as +0.
        if (mag_r == '0) begin
            sgn_r = 1'b0;
        end
        sum_o = {sgn_r, mag_r};
    end

endmodule

// File: rtl/qsm_accum.sv
// Sequential sign-magnitude accumulator: sums i_len streamed samples and
// emits the result with a one-cycle acc_res_vld pulse.
// Optional feature: QSM_ACCUM_SAT_EN (saturating add, see qsm_add_core).
module qsm_accum
    import qsm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [LW-1:0] i_len,
    input  logic          s_vld,
    input  logic [N-1:0]  s_dat,
    output logic          s_rdy,
    output logic [N-1:0]  acc_res,
    output logic          acc_res_vld,
    output logic          acc_ovf,
    output logic          busy
);

    qsm_state_e    state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  res_q, res_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [N-1:0]  add_sum;
    logic          add_ovf;

    qsm_add_core u_add_core (
        .a_i   (acc_q),
        .b_i   (s_dat),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    // Next-state, datapath updates and decoded outputs.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        s_rdy       = 1'b0;
        busy        = 1'b0;
        acc_res_vld = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    acc_d = POS_ZERO;
                    ovf_d = 1'b0;
                    cnt_d = i_len;
                    if (i_len == '0) begin
                        res_d   = POS_ZERO;
                        state_d = StDone;
                    end else begin
                        state_d = StAcc;
                    end
                end
            end
            StAcc: begin
                s_rdy = 1'b1;
                busy  = 1'b1;
                if (s_vld) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_q - 1'b1;
                    // Result register loads on the final accept so it is
                    // already valid while DONE raises the pulse.
                    if (cnt_q == LW'(1)) begin
                        res_d   = add_sum;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                busy        = 1'b1;
                acc_res_vld = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= POS_ZERO;
            res_q   <= POS_ZERO;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc_res = res_q;
    assign acc_ovf = ovf_q;

endmodule

// File: tb/tb_qsm_accum.sv
// Self-checking bench for qsm_accum: directed cases plus randomized runs
// compared against a signed-integer reference model.
module tb_qsm_accum;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [15:0] i_len;
    logic        s_vld;
    logic [31:0] s_dat;
    logic        s_rdy;
    logic [31:0] acc_res;
    logic        acc_res_vld;
    logic        acc_ovf;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] smp_q[$];

    qsm_accum dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_len       (i_len),
        .s_vld       (s_vld),
        .s_dat       (s_dat),
        .s_rdy       (s_rdy),
        .acc_res     (acc_res),
        .acc_res_vld (acc_res_vld),
        .acc_ovf     (acc_ovf),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference add on signed integers: {ovf, result}.
    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        longint va, vb, s, m;
        logic [31:0] r;
        logic ov;
        va = longint'(a[30:0]);
        vb = longint'(b[30:0]);
        if (a[31]) va = -va;
        if (b[31]) vb = -vb;
        s  = va + vb;
        m  = (s < 0) ? -s : s;
        ov = (m > 64'sd2147483647);
        if (ov) begin
`ifdef QSM_ACCUM_SAT_EN
            m = 64'sd2147483647;
`else
            m = m - 64'sd2147483648;
`endif
        end
        r[30:0] = m[30:0];
        r[31]   = (s < 0) && (m != 0);
        return {ov, r};
    endfunction

    // Runs one transaction over smp_q and checks it against the model.
    task automatic do_run(input string tag, input bit gaps, input bit poke_start);
        logic [31:0] exp_res;
        logic        exp_ovf;
        logic [32:0] step;
        int          len;
        int          idx;
        int          guard;
        bit          accepted;
        bit          early_vld;
        bit          got_vld;
        len     = smp_q.size();
        exp_res = 32'h0;
        exp_ovf = 1'b0;
        foreach (smp_q[k]) begin
            step    = ref_add(exp_res, smp_q[k]);
            exp_res = step[31:0];
            exp_ovf = exp_ovf | step[32];
        end
        @(negedge clk);
        i_start = 1'b1;
        i_len   = 16'(len);
        @(negedge clk);
        if (!poke_start) i_start = 1'b0;
        if (poke_start) i_len = 16'h0;
        idx       = 0;
        guard     = 0;
        early_vld = 1'b0;
        while (idx < len && guard < 500) begin
            s_vld    = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_dat    = s_vld ? smp_q[idx] : $urandom();
            accepted = s_vld && s_rdy;
            if (acc_res_vld) early_vld = 1'b1;
            @(negedge clk);
            if (accepted) idx++;
            guard++;
        end
        s_vld   = 1'b0;
        i_start = 1'b0;
        check_eq({tag, "_samples_taken"}, 32'(idx), 32'(len));
        check_eq({tag, "_early_vld"}, 32'(early_vld), 32'h0);
        got_vld = acc_res_vld;
        if (len == 0) begin
            check_eq({tag, "_rdy_len0"}, 32'(s_rdy), 32'h0);
            if (!got_vld) begin
                @(negedge clk);
                got_vld = acc_res_vld;
            end
        end
        check_eq({tag, "_vld"}, 32'(got_vld), 32'h1);
        check_eq({tag, "_res"}, acc_res, exp_res);
        check_eq({tag, "_ovf"}, 32'(acc_ovf), 32'(exp_ovf));
        check_eq({tag, "_busy_done"}, 32'(busy), 32'h1);
        @(negedge clk);
        check_eq({tag, "_vld_pulse"}, 32'(acc_res_vld), 32'h0);
        check_eq({tag, "_idle"}, 32'(busy), 32'h0);
        check_eq({tag, "_res_hold"}, acc_res, exp_res);
    endtask

    function automatic logic [31:0] rand_sample();
        int sel;
        sel = $urandom_range(0, 4);
        case (sel)
            0:       return $urandom();
            1:       return {1'($urandom_range(0, 1)), 2'b11, 29'($urandom())};
            2:       return {1'($urandom_range(0, 1)), 31'($urandom_range(0, 255))};
            3:       return 32'h8000_0000;
            default: return {1'($urandom_range(0, 1)), 8'h0, 23'($urandom())};
        endcase
    endfunction

    initial begin
        rst     = 1'b1;
        i_start = 1'b0;
        i_len   = 16'h0;
        s_vld   = 1'b0;
        s_dat   = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_res", acc_res, 32'h0);
        check_eq("rst_vld", 32'(acc_res_vld), 32'h0);
        check_eq("rst_ovf", 32'(acc_ovf), 32'h0);
        check_eq("rst_rdy", 32'(s_rdy), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        smp_q = '{32'h0080_0000, 32'h0040_0000, 32'h0020_0000};
        do_run("t1", 1'b0, 1'b0);
        check_eq("t1_const", acc_res, 32'h00E0_0000);

        smp_q = '{32'h0080_0000, 32'h8080_0000};
        do_run("t2", 1'b0, 1'b0);
        check_eq("t2_const", acc_res, 32'h0000_0000);

        smp_q = '{32'h0040_0000, 32'h80C0_0000};
        do_run("t3", 1'b0, 1'b0);
        check_eq("t3_const", acc_res, 32'h8080_0000);

        smp_q = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        do_run("t4", 1'b0, 1'b0);
`ifdef QSM_ACCUM_SAT_EN
        check_eq("t4_const", acc_res, 32'h7FFF_FFFF);
`else
        check_eq("t4_const", acc_res, 32'h7FFF_FFFE);
`endif
        check_eq("t4_ovf_const", 32'(acc_ovf), 32'h1);

        smp_q = '{};
        do_run("t5_len0", 1'b0, 1'b0);
        check_eq("t5_len0_const", acc_res, 32'h0);

        smp_q = '{32'h0100_0000, 32'h8030_0000, 32'h0008_0000, 32'h8000_0000};
        do_run("t5_gapless", 1'b0, 1'b0);
        check_eq("t5_gapless_const", acc_res, 32'h00D8_0000);
        do_run("t5_gaps", 1'b1, 1'b0);
        check_eq("t5_gaps_const", acc_res, 32'h00D8_0000);

        // Abort after two of four samples.
        @(negedge clk);
        i_start = 1'b1;
        i_len   = 16'd4;
        @(negedge clk);
        i_start = 1'b0;
        s_vld   = 1'b1;
        s_dat   = 32'h0100_0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_res", acc_res, 32'h0);
        check_eq("t6_rst_rdy", 32'(s_rdy), 32'h0);
        check_eq("t6_rst_busy", 32'(busy), 32'h0);
        check_eq("t6_rst_ovf", 32'(acc_ovf), 32'h0);
        rst = 1'b0;
        begin
            bit pulse;
            pulse = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (acc_res_vld || s_rdy) pulse = 1'b1;
            end
            check_eq("t6_no_pulse", 32'(pulse), 32'h0);
        end
        s_vld = 1'b0;

        smp_q = '{32'h0080_0000, 32'h0080_0000, 32'h8020_0000};
        do_run("t6_busy_start", 1'b0, 1'b1);
        check_eq("t6_after_const", acc_res, 32'h00E0_0000);

        for (int r = 0; r < 25; r++) begin
            int len;
            len   = $urandom_range(0, 7);
            smp_q = '{};
            for (int k = 0; k < len; k++) smp_q.push_back(rand_sample());
            do_run($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
